// File: rtl/stage3_prefetch_pkg.sv
// rtl/stage3_prefetch_pkg.sv - shared types and constants for the stage-3 instruction prefetch buffer
package stage3_prefetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FLUSH
  } prefetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } prefetch_entry_t;

  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/stage3_prefetch_fifo.sv
// rtl/stage3_prefetch_fifo.sv - power-of-two {pc, inst} FIFO with push/pop/clear, count, full and empty
module stage3_prefetch_fifo import stage3_prefetch_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [31:0]              push_pc,
  input  logic [31:0]              push_inst,
  input  logic                     pop,
  output logic [31:0]              head_pc,
  output logic [31:0]              head_inst,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [PW:0]   CNT_ONE = 1;
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);

  prefetch_entry_t mem [DEPTH];
  logic [PW-1:0]   head_ptr;
  logic [PW-1:0]   tail_ptr;
  logic            pop_ok;
  logic            push_ok;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign head_pc   = mem[head_ptr].pc;
  assign head_inst = mem[head_ptr].inst;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push_ok) tail_ptr <= tail_ptr + PTR_ONE;
      if (pop_ok)  head_ptr <= head_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through a nonzero count.
  always_ff @(posedge clk) begin
    if (!rst && !clear && push_ok) begin
      mem[tail_ptr] <= '{pc: push_pc, inst: push_inst};
    end
  end

endmodule

// File: rtl/stage3_prefetch_buffer.sv
// rtl/stage3_prefetch_buffer.sv - sequential instruction prefetcher feeding the fetch stage
// Optional counters: define STAGE3_PREFETCH_STATS_EN for stat_fetches/stat_discards/stat_empty_stalls.
module stage3_prefetch_buffer import stage3_prefetch_pkg::*; #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [31:0] bus_addr,
  output logic        bus_ren,
  input  logic [31:0] bus_rdata,
  input  logic        bus_busy,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_fetch,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        empty
`ifdef STAGE3_PREFETCH_STATS_EN
  ,
  output logic [31:0] stat_fetches,
  output logic [31:0] stat_discards,
  output logic [31:0] stat_empty_stalls
`endif
);

  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [31:0] STRIDE  = 32'(WORD_BYTES);

  prefetch_state_t state, state_nxt;
  logic [31:0]     fetch_pc, fetch_pc_nxt;
  logic [31:0]     flush_addr, flush_addr_nxt;
  logic [31:0]     redirect_target;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_after;
  logic            fifo_full;
  logic            fifo_empty;
  logic [31:0]     head_pc;
  logic [31:0]     head_inst;
  logic            completion;
  logic            push;
  logic            pop;

  assign redirect_target = redirect_pc & ~(STRIDE - 32'd1);
  assign bus_ren         = (state != IDLE);
  assign bus_addr        = (state == FLUSH) ? flush_addr : fetch_pc;
  assign completion      = bus_ren && !bus_busy;
  assign push            = completion && (state == REQ) && !redirect_valid;
  assign pop             = !fifo_empty && inst_ready && !redirect_valid;
  assign count_after     = count + CW'(push) - CW'(pop);

  assign inst_valid = !fifo_empty;
  assign inst       = fifo_empty ? '0 : head_inst;
  assign inst_pc    = fifo_empty ? '0 : head_pc;
  assign empty      = fifo_empty;

  stage3_prefetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .clear     (redirect_valid),
    .push      (push),
    .push_pc   (fetch_pc),
    .push_inst (bus_rdata),
    .pop       (pop),
    .head_pc   (head_pc),
    .head_inst (head_inst),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_nxt      = state;
    fetch_pc_nxt   = fetch_pc;
    flush_addr_nxt = flush_addr;
    if (redirect_valid) fetch_pc_nxt = redirect_target;
    case (state)
      IDLE: begin
        if (!redirect_valid && !halt_fetch && (!fifo_full || pop)) state_nxt = REQ;
      end
      REQ: begin
        if (redirect_valid) begin
          // A stalled request cannot be withdrawn, so it is drained in FLUSH at its old address.
          if (bus_busy) begin
            state_nxt      = FLUSH;
            flush_addr_nxt = fetch_pc;
          end else begin
            state_nxt = halt_fetch ? IDLE : REQ;
          end
        end else if (!bus_busy) begin
          fetch_pc_nxt = fetch_pc + STRIDE;
          state_nxt    = (!halt_fetch && (count_after < DEPTH_C)) ? REQ : IDLE;
        end
      end
      FLUSH: begin
        if (!bus_busy) state_nxt = halt_fetch ? IDLE : REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      flush_addr <= RESET_PC;
    end else begin
      state      <= state_nxt;
      fetch_pc   <= fetch_pc_nxt;
      flush_addr <= flush_addr_nxt;
    end
  end

`ifdef STAGE3_PREFETCH_STATS_EN
  logic        discard_done;
  logic [32:0] discard_sum;

  assign discard_done = completion && (redirect_valid || (state == FLUSH));
  assign discard_sum  = {1'b0, stat_discards} + 33'(redirect_valid ? count : '0) + 33'(discard_done);

  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_fetches      <= '0;
      stat_discards     <= '0;
      stat_empty_stalls <= '0;
    end else begin
      if (push && (stat_fetches != '1)) stat_fetches <= stat_fetches + 32'd1;
      stat_discards <= discard_sum[32] ? '1 : discard_sum[31:0];
      if (inst_ready && fifo_empty && (stat_empty_stalls != '1)) begin
        stat_empty_stalls <= stat_empty_stalls + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_stage3_prefetch_buffer.sv
// tb/tb_stage3_prefetch_buffer.sv - directed and randomized checks of the prefetch buffer against a queue model
module tb_stage3_prefetch_buffer;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] bus_addr;
  logic        bus_ren;
  logic [31:0] bus_rdata;
  logic        bus_busy = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt_fetch = 1'b0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        empty;

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  assign bus_rdata = mem_word(bus_addr);

  stage3_prefetch_buffer #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .bus_addr       (bus_addr),
    .bus_ren        (bus_ren),
    .bus_rdata      (bus_rdata),
    .bus_busy       (bus_busy),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_fetch     (halt_fetch),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .empty          (empty)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          dut_compl = 0;
  logic [31:0] q[$];
  logic [31:0] m_fetch;
  logic [31:0] m_flush_addr;
  bit          m_flushing;
  bit          exp_ren;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RST = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    halt_fetch = 1'b0; bus_busy = 1'b0; inst_ready = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check("rst_ren", 32'(bus_ren), 32'd0);
    check("rst_addr", bus_addr, RESET_PC);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_pc", inst_pc, 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    q.delete();
    m_fetch = RESET_PC; m_flush_addr = RESET_PC; m_flushing = 0; exp_ren = 0;
    dut_compl = 0;
  endtask

  // One clock: drive inputs, compare outputs with the model, then advance the model past the edge.
  task automatic step(input bit rv, input logic [31:0] rpc, input bit halt, input bit busy, input bit rdy);
    int sz;
    bit compl, pop, nxt_ren;
    @(posedge CLK); #1;
    RST = 1'b0; redirect_valid = rv; redirect_pc = rpc;
    halt_fetch = halt; bus_busy = busy; inst_ready = rdy;
    @(negedge CLK);
    sz = q.size();
    check("bus_ren", 32'(bus_ren), 32'(exp_ren));
    if (exp_ren) check("bus_addr", bus_addr, m_flushing ? m_flush_addr : m_fetch);
    check("inst_valid", 32'(inst_valid), (sz > 0) ? 32'd1 : 32'd0);
    check("empty", 32'(empty), (sz == 0) ? 32'd1 : 32'd0);
    if (sz > 0) begin
      check("inst_pc", inst_pc, q[0]);
      check("inst", inst, mem_word(q[0]));
    end
    if (bus_ren && !busy) dut_compl++;

    compl = exp_ren && !busy;
    pop   = (sz > 0) && rdy && !rv;
    if (exp_ren && busy)      nxt_ren = 1;
    else if (halt)            nxt_ren = 0;
    else if (!exp_ren)        nxt_ren = !rv && ((sz < DEPTH) || pop);
    else if (rv || m_flushing) nxt_ren = 1;
    else                      nxt_ren = ((sz + 1 - int'(pop)) < DEPTH);

    if (rv) begin
      q.delete();
      if (exp_ren && busy && !m_flushing) begin
        m_flushing   = 1;
        m_flush_addr = m_fetch;
      end else if (compl) begin
        m_flushing = 0;
      end
      m_fetch = rpc & 32'hFFFF_FFFC;
    end else begin
      if (pop) void'(q.pop_front());
      if (compl) begin
        if (m_flushing) m_flushing = 0;
        else begin
          q.push_back(m_fetch);
          m_fetch = m_fetch + 32'd4;
        end
      end
    end
    exp_ren = nxt_ren;
  endtask

  bit          r_rv, r_halt, r_busy, r_rdy;
  logic [31:0] r_pc;

  initial begin
    // Streaming from reset with a zero-wait bus.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(0, '0, 0, 0, 1);
      check("seq_valid", 32'(inst_valid), (i >= 2) ? 32'd1 : 32'd0);
      if (i >= 1) check("seq_addr", bus_addr, RESET_PC + 32'(4 * (i - 1)));
      if (i >= 2) check("seq_pc", inst_pc, RESET_PC + 32'(4 * (i - 2)));
    end

    // Fill with no consumer, then resume.
    do_reset();
    for (int i = 0; i < 8; i++) step(0, '0, 0, 0, 0);
    check("fill_compl", 32'(dut_compl), 32'd4);
    check("fill_ren", 32'(bus_ren), 32'd0);
    check("fill_head", inst_pc, 32'h8000_0000);
    step(0, '0, 0, 0, 1);
    check("resume_idle", 32'(bus_ren), 32'd0);
    step(0, '0, 0, 0, 0);
    check("resume_ren", 32'(bus_ren), 32'd1);
    check("resume_addr", bus_addr, 32'h8000_0010);

    // Redirect while the bus stalls.
    do_reset();
    for (int i = 0; i < 3; i++) step(0, '0, 0, 0, 1);
    step(1, 32'h8000_1002, 0, 1, 1);
    check("flush_addr0", bus_addr, 32'h8000_0008);
    for (int i = 0; i < 2; i++) begin
      step(0, '0, 0, 1, 1);
      check("flush_hold", bus_addr, 32'h8000_0008);
      check("flush_novalid", 32'(inst_valid), 32'd0);
    end
    step(0, '0, 0, 0, 1);
    check("flush_done", bus_addr, 32'h8000_0008);
    step(0, '0, 0, 0, 1);
    check("redir_addr", bus_addr, 32'h8000_1000);
    check("redir_novalid", 32'(inst_valid), 32'd0);
    step(0, '0, 0, 0, 1);
    check("redir_pc", inst_pc, 32'h8000_1000);

    // Redirect on a completion with a pop pending.
    do_reset();
    for (int i = 0; i < 3; i++) step(0, '0, 0, 0, 1);
    step(1, 32'h8000_2000, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    check("rc_empty", 32'(empty), 32'd1);
    check("rc_addr", bus_addr, 32'h8000_2000);

    // Address wrap at the top of the space.
    do_reset();
    step(1, 32'hFFFF_FFFC, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    check("wrap_hi", bus_addr, 32'hFFFF_FFFC);
    step(0, '0, 0, 0, 1);
    check("wrap_lo", bus_addr, 32'h0000_0000);
    check("wrap_pc", inst_pc, 32'hFFFF_FFFC);

    // Halt while a request is stalled.
    do_reset();
    step(0, '0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, '0, 1, 1, 0);
    step(0, '0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, '0, 1, 0, 0);
      check("halt_ren", 32'(bus_ren), 32'd0);
    end
    check("halt_compl", 32'(dut_compl), 32'd1);
    check("halt_pc", inst_pc, 32'h8000_0000);

    // Randomized traffic.
    do_reset();
    r_halt = 0;
    for (int i = 0; i < 3000; i++) begin
      r_rv   = ($urandom_range(0, 19) == 0);
      r_pc   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
      if ($urandom_range(0, 9) == 0) r_halt = !r_halt;
      r_busy = ($urandom_range(0, 2) == 0);
      r_rdy  = ($urandom_range(0, 2) != 0);
      step(r_rv, r_pc, r_halt, r_busy, r_rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
